alu_seq_param: RTL and testbench

Parametrised sequential ALU, next generation of the 8-bit multi-op ALU. Operands and results cross a single WIDTH-bit data bus, as in the existing ALU, and the block adds a WIDTH generic, a busy/out_valid handshake and a divide-by-zero flag. It performs add, subtract, signed radix-4 Booth multiply and unsigned division. It sits behind the same BEGIN/END control interface the system bus already drives.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/adder_rca.sv | 26 ++
 rtl/booth4_recoder.sv | 16 +
 rtl/alu_seq_param.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_param.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and the radix-4 Booth digit layout.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_Y = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] OUT_HI = 3'd3;
   localparam logic [2:0] OUT_LO = 3'd4;

   // One Booth digit in {0, +-1, +-2} form: magnitude is 0, 1 or 2 times X.
   typedef struct packed {
      logic zero;
      logic neg;
      logic two;
   } booth_digit_t;

endpackage

// File: rtl/adder_rca.sv
// Ripple-carry adder; subtraction is done by the caller inverting b and
// setting carry_in.
module adder_rca #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = carry_in;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      carry_out = c[WIDTH];
   end

endmodule

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: {y[i+1], y[i], y[i-1]} to a signed digit in {0, +-X, +-2X}.
module booth4_recoder
   import alu_seq_pkg::*;
(
   input  logic [2:0]   bits,
   output booth_digit_t digit
);

   always_comb begin
      digit      = '0;
      digit.zero = (bits == 3'b000) || (bits == 3'b111);
      digit.neg  = bits[2] & ~(bits[1] & bits[0]);
      digit.two  = (bits == 3'b011) || (bits == 3'b100);
   end

endmodule

// File: rtl/alu_seq_param.sv
// Sequential ALU: add/sub in one cycle, signed radix-4 Booth multiply and
// unsigned restoring division iterated in EXEC, results returned as hi/lo beats.
module alu_seq_param
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BEGIN,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             out_valid,
   output logic             busy,
   output logic             END,
   output logic             div_by_zero,
   output logic [2:0]       state_debug
);

   localparam int unsigned N  = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   logic [2:0]       state, state_nxt;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] xr, yr;
   logic [N-1:0]     acc;
   logic             y_m1;
   logic [CW-1:0]    cnt;
   logic             dbz_r, busy_r, valid_r;

   logic             exec_done;
   booth_digit_t     digit;
   logic [N-1:0]     pp_mag;
   logic [N-1:0]     add_a, add_b, add_sum;
   logic             add_cin, add_co;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] hi, lo;

   booth4_recoder u_recoder (
      .bits  ({yr[1], yr[0], y_m1}),
      .digit (digit)
   );

   adder_rca #(.WIDTH(N)) u_adder (
      .a         (add_a),
      .b         (add_b),
      .carry_in  (add_cin),
      .sum       (add_sum),
      .carry_out (add_co)
   );

   // For DIV, xr holds the divisor and yr shifts the dividend out / quotient in.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      pp_mag  = '0;
      rem_sh  = {acc[WIDTH-1:0], yr[WIDTH-1]};
      case (op_r)
         OP_ADD: begin
            add_a = {2'b00, xr};
            add_b = {2'b00, yr};
         end
         OP_SUB: begin
            add_a   = {2'b00, xr};
            add_b   = ~{2'b00, yr};
            add_cin = 1'b1;
         end
         OP_MUL: begin
            if (!digit.zero)
               pp_mag = digit.two ? {xr[WIDTH-1], xr, 1'b0} : {{2{xr[WIDTH-1]}}, xr};
            add_a   = acc;
            add_b   = digit.neg ? ~pp_mag : pp_mag;
            add_cin = digit.neg;
         end
         default: begin
            add_a   = {1'b0, rem_sh};
            add_b   = ~{2'b00, xr};
            add_cin = 1'b1;
         end
      endcase
   end

   always_comb begin
      exec_done = 1'b1;
      case (op_r)
         OP_MUL:  exec_done = (cnt == MUL_LAST);
         OP_DIV:  exec_done = dbz_r || (cnt == DIV_LAST);
         default: exec_done = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (BEGIN) state_nxt = LOAD_Y;
         LOAD_Y:  state_nxt = EXEC;
         EXEC:    if (exec_done) state_nxt = OUT_HI;
         OUT_HI:  state_nxt = OUT_LO;
         OUT_LO:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         op_r    <= '0;
         xr      <= '0;
         yr      <= '0;
         acc     <= '0;
         y_m1    <= 1'b0;
         cnt     <= '0;
         dbz_r   <= 1'b0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         state   <= state_nxt;
         busy_r  <= (state_nxt != IDLE);
         valid_r <= (state_nxt == OUT_HI) || (state_nxt == OUT_LO);
         case (state)
            IDLE: begin
               if (BEGIN) begin
                  xr    <= inbus;
                  op_r  <= op_code;
                  dbz_r <= 1'b0;
               end
            end
            LOAD_Y: begin
               cnt  <= '0;
               acc  <= '0;
               y_m1 <= 1'b0;
               if (op_r == OP_DIV) begin
                  yr    <= xr;
                  xr    <= inbus;
                  dbz_r <= (inbus == '0);
               end else begin
                  yr <= inbus;
               end
            end
            EXEC: begin
               cnt <= cnt + CW'(1);
               case (op_r)
                  OP_ADD, OP_SUB: acc <= add_sum;
                  OP_MUL: begin
                     acc  <= {{2{add_sum[N-1]}}, add_sum[N-1:2]};
                     yr   <= {add_sum[1:0], yr[WIDTH-1:2]};
                     y_m1 <= yr[1];
                  end
                  default: begin
                     // carry out of R - Y means no borrow: keep difference, quotient bit 1
                     if (!dbz_r) begin
                        acc <= add_co ? {2'b00, add_sum[WIDTH-1:0]} : {2'b00, rem_sh[WIDTH-1:0]};
                        yr  <= {yr[WIDTH-2:0], add_co};
                     end
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      hi = acc[WIDTH-1:0];
      lo = yr;
      case (op_r)
         OP_ADD, OP_SUB: begin
            hi = {{(WIDTH-1){1'b0}}, acc[WIDTH]};
            lo = acc[WIDTH-1:0];
         end
         OP_DIV: begin
            if (dbz_r) begin
               hi = yr;
               lo = '1;
            end
         end
         default: ;
      endcase
   end

   assign outbus      = (state == OUT_HI) ? hi : (state == OUT_LO) ? lo : '0;
   assign END         = (state == OUT_LO);
   assign out_valid   = valid_r;
   assign busy        = busy_r;
   assign div_by_zero = dbz_r;
   assign state_debug = state;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=8): result beats are scoreboarded
// with their expected cycle, control outputs are checked inline.
module tb_alu_seq_param;

   logic       clk;
   logic       reset;
   logic       BEGIN;
   logic [1:0] op_code;
   logic [7:0] inbus;
   logic [7:0] outbus;
   logic       out_valid, busy, END, div_by_zero;
   logic [2:0] state_debug;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         cyc;
   } beat_t;

   beat_t sb[$];

   alu_seq_param #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .BEGIN       (BEGIN),
      .op_code     (op_code),
      .inbus       (inbus),
      .outbus      (outbus),
      .out_valid   (out_valid),
      .busy        (busy),
      .END         (END),
      .div_by_zero (div_by_zero),
      .state_debug (state_debug)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      beat_t b;
      if (out_valid) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_beat: got outbus=%0h END=%0b exp=no beat", outbus, END);
         end
         if (sb.size() != 0) begin
            b = sb.pop_front();
            chk("beat_data", {24'd0, outbus}, {24'd0, b.data});
            chk("beat_end", {31'd0, END}, {31'd0, b.last});
            chk("beat_cycle", cyc, b.cyc);
         end
      end else begin
         chk("idle_bus", {23'd0, END, outbus}, 32'd0);
      end
   end

   // Called at cycle 0 (IDLE); returns at cycle 4+e, ready for a back-to-back BEGIN.
   task automatic run_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] hi, input logic [7:0] lo, input int e,
                         input logic dbz, input int pulse_at);
      int c0;
      c0 = cyc;
      BEGIN   = 1'b1;
      op_code = op;
      inbus   = x;
      sb.push_back('{hi, 1'b0, c0 + 2 + e});
      sb.push_back('{lo, 1'b1, c0 + 3 + e});
      tick;
      BEGIN   = 1'b0;
      inbus   = y;
      op_code = 2'($urandom);
      chk("busy_load", {31'd0, busy}, 32'd1);
      chk("state_load", {29'd0, state_debug}, 32'd1);
      chk("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
      for (int k = 2; k <= 4 + e; k++) begin
         tick;
         BEGIN = 1'b0;
         inbus = 8'($urandom);
         if (k == pulse_at) begin
            BEGIN   = 1'b1;
            op_code = 2'($urandom);
         end
         if (k == 3 + e) chk("dbz_at_end", {31'd0, div_by_zero}, {31'd0, dbz});
      end
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("state_idle", {29'd0, state_debug}, 32'd0);
   endtask

   initial begin
      reset   = 1'b0;
      BEGIN   = 1'b0;
      op_code = 2'b00;
      inbus   = 8'h00;
      tick;
      tick;
      chk("rst_outbus", {24'd0, outbus}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_end", {31'd0, END}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("rst_state", {29'd0, state_debug}, 32'd0);
      reset = 1'b1;
      tick;
      tick;

      run_op(2'b00, 8'hF0, 8'h20, 8'h01, 8'h10, 1, 1'b0, -1);
      tick;
      run_op(2'b01, 8'h05, 8'h07, 8'h01, 8'hFE, 1, 1'b0, -1);
      run_op(2'b00, 8'h01, 8'h01, 8'h00, 8'h02, 1, 1'b0, -1);
      tick;
      run_op(2'b10, 8'hFD, 8'h07, 8'hFF, 8'hEB, 4, 1'b0, 3);
      run_op(2'b10, 8'h80, 8'h80, 8'h40, 8'h00, 4, 1'b0, -1);
      run_op(2'b10, 8'h7F, 8'h80, 8'hC0, 8'h80, 4, 1'b0, -1);
      run_op(2'b11, 8'hC8, 8'h07, 8'h04, 8'h1C, 8, 1'b0, -1);
      run_op(2'b11, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1, 1'b1, -1);
      for (int k = 0; k < 3; k++) tick;
      chk("dbz_held", {31'd0, div_by_zero}, 32'd1);

      // DIV aborted by reset at cycle 4; no beats are expected from it
      BEGIN   = 1'b1;
      op_code = 2'b11;
      inbus   = 8'hC8;
      tick;
      BEGIN = 1'b0;
      inbus = 8'h07;
      chk("dbz_clr_abort", {31'd0, div_by_zero}, 32'd0);
      tick;
      tick;
      tick;
      chk("busy_before_abort", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_outbus", {24'd0, outbus}, 32'd0);
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_end", {31'd0, END}, 32'd0);
      chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("abort_state", {29'd0, state_debug}, 32'd0);
      tick;
      reset = 1'b1;
      for (int k = 0; k < 15; k++) tick;
      chk("post_abort_state", {29'd0, state_debug}, 32'd0);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);

      run_op(2'b11, 8'h09, 8'h02, 8'h01, 8'h04, 8, 1'b0, -1);
      run_op(2'b11, 8'hFF, 8'h01, 8'h00, 8'hFF, 8, 1'b0, -1);
      run_op(2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 1'b0, -1);
      run_op(2'b01, 8'h07, 8'h07, 8'h00, 8'h00, 1, 1'b0, -1);

      for (int k = 0; k < 5; k++) tick;
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
